// File: rtl/mult_div.sv
// mult_div: sequential signed multiply / divide unit.
// Multiply uses radix-2 Booth, one bit per cycle (33-cycle latency).
// Divide uses restoring division on magnitudes, then a sign-fix cycle (34 cycles).
// Optional macro MULT_DIV_DIVZERO_CHECK_EN: a divide by zero finishes immediately
// with DivZero asserted; without it the divide runs normally and DivZero stays 0.
module mult_div #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             MultStart,
    input  logic             DivStart,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;     // multiplicand, or divisor magnitude
    logic [WIDTH-1:0] mplr;      // multiplier / low product, or quotient
    logic [WIDTH:0]   acc;       // high partial product, or remainder in [WIDTH-1:0]
    logic             booth;
    logic             neg_q, neg_r;
    logic             last_iter;

    logic [WIDTH:0]   sum, acc_m;
    logic [WIDTH-1:0] mplr_m;
    logic [WIDTH:0]   shifted, diff;
    logic             fits;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic             busy_nxt, done_nxt, dz_nxt;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;

    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign a_mag     = A[WIDTH-1] ? -A : A;
    assign b_mag     = B[WIDTH-1] ? -B : B;

    // Booth step: add/sub by the bit pair, then arithmetic shift of {acc, mplr}
    always_comb begin
        sum = acc;
        case ({mplr[0], booth})
            2'b01:   sum = acc + {mcand[WIDTH-1], mcand};
            2'b10:   sum = acc - {mcand[WIDTH-1], mcand};
            default: sum = acc;
        endcase
        acc_m  = {sum[WIDTH], sum[WIDTH:1]};
        mplr_m = {sum[0], mplr[WIDTH-1:1]};
    end

    // Restoring divide step: shift in next dividend bit, subtract if it fits
    always_comb begin
        shifted = {acc[WIDTH-1:0], mplr[WIDTH-1]};
        fits    = (shifted >= {1'b0, mcand});
        diff    = shifted - {1'b0, mcand};
        rem_d   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d   = {mplr[WIDTH-2:0], fits};
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; MultStart has priority over DivStart
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (MultStart)
                    state_nxt = MULT;
                else if (DivStart) begin
`ifdef MULT_DIV_DIVZERO_CHECK_EN
                    state_nxt = (B == '0) ? DONE : DIV;
`else
                    state_nxt = DIV;
`endif
                end
            end
            MULT:    if (last_iter) state_nxt = DONE;
            DIV:     if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        busy_nxt = (state_nxt == MULT) || (state_nxt == DIV) || (state_nxt == FIX);
        done_nxt = (state_nxt == DONE);
`ifdef MULT_DIV_DIVZERO_CHECK_EN
        dz_nxt   = (state == IDLE) && (state_nxt == DONE);
`else
        dz_nxt   = 1'b0;
`endif
        hi_nxt   = HI;
        lo_nxt   = LO;
        if (state == MULT && last_iter) begin
            hi_nxt = acc_m[WIDTH-1:0];
            lo_nxt = mplr_m;
        end else if (state == FIX) begin
            hi_nxt = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            lo_nxt = neg_q ? -mplr : mplr;
        end
    end

    // Registered outputs; HI/LO only move when an operation completes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            HI      <= '0;
            LO      <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            HI      <= hi_nxt;
            LO      <= lo_nxt;
            Busy    <= busy_nxt;
            Done    <= done_nxt;
            DivZero <= dz_nxt;
        end
    end

    // Datapath: operand capture in IDLE, one iteration per cycle in MULT/DIV
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            booth <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (MultStart) begin
                        mcand <= A;
                        mplr  <= B;
                        acc   <= '0;
                        booth <= 1'b0;
                    end else if (DivStart) begin
                        mcand <= b_mag;
                        mplr  <= a_mag;
                        acc   <= '0;
                        neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
                        neg_r <= A[WIDTH-1];
                    end
                end
                MULT: begin
                    acc   <= acc_m;
                    mplr  <= mplr_m;
                    booth <= mplr[0];
                    cnt   <= cnt + 1'b1;
                end
                DIV: begin
                    acc   <= {1'b0, rem_d};
                    mplr  <= quo_d;
                    cnt   <= cnt + 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: scoreboard of expected HI/LO/latency per op.
module tb_mult_div;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        MultStart = 1'b0;
    logic        DivStart = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] HI, LO;
    logic        Busy, Done, DivZero;

    always #5 clock = ~clock;

    mult_div #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .MultStart(MultStart), .DivStart(DivStart),
        .A(A), .B(B), .HI(HI), .LO(LO), .Busy(Busy), .Done(Done), .DivZero(DivZero)
    );

    typedef struct {
        logic [63:0] hl;
        int          lat;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          dz_cnt = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    always @(negedge clock) begin
        if (Done)    done_cnt++;
        if (DivZero) dz_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    function automatic logic [63:0] m_div(input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        x = longint'($signed(a));
        y = longint'($signed(b));
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Drive one start pulse, then wait for Done and check against the scoreboard
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] ehl, input int elat, input logic edz,
                          input int ebusy, input int stray_at);
        exp_t e;
        int   cyc, busy_n, d0;
        e.hl = ehl; e.lat = elat; e.dz = edz;
        sb.push_back(e);
        d0 = done_cnt;
        @(negedge clock);
        MultStart = m; DivStart = d; A = a; B = b;
        @(negedge clock);
        MultStart = 0; DivStart = 0; A = $urandom; B = $urandom;
        cyc = 1; busy_n = 0;
        while (!Done && cyc < 80) begin
            if (Busy) busy_n++;
            if (cyc == 16) chk({tag, "_hold"}, {HI, LO}, {cur_hi, cur_lo});
            DivStart = (cyc == stray_at);
            @(negedge clock);
            cyc++;
        end
        DivStart = 0;
        e = sb.pop_front();
        if (!Done) begin
            chk({tag, "_timeout"}, 64'(cyc), 64'(e.lat));
            return;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(e.lat));
        chk({tag, "_hilo"}, {HI, LO}, e.hl);
        chk({tag, "_dz"}, 64'(DivZero), 64'(e.dz));
        chk({tag, "_busy"}, 64'(busy_n), 64'(ebusy));
        {cur_hi, cur_lo} = e.hl;
        @(negedge clock);
        chk({tag, "_pulse"}, 64'(Done), 64'(0));
        if (stray_at > 0) begin
            repeat (40) @(negedge clock);
            chk({tag, "_ndone"}, 64'(done_cnt - d0), 64'(1));
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        repeat (3) @(negedge clock);
        chk("rst_hilo", {HI, LO}, 64'(0));
        chk("rst_ctl", {61'(0), Busy, Done, DivZero}, 64'(0));
        reset = 1;

        run_op("mul_7x-3", 1, 0, 32'd7, 32'hFFFFFFFD, {32'hFFFFFFFF, 32'hFFFFFFEB}, 33, 0, 32, 0);
        run_op("mul_min2", 1, 0, 32'h80000000, 32'h80000000, {32'h40000000, 32'h0}, 33, 0, 32, 0);
        run_op("div_-7/2", 0, 1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 0, 33, 0);
        run_op("div_ovf", 0, 1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34, 0, 33, 0);
`ifdef MULT_DIV_DIVZERO_CHECK_EN
        run_op("div_zero", 0, 1, 32'd10, 32'd0, {cur_hi, cur_lo}, 1, 1, 0, 0);
`else
        run_op("div_zero", 0, 1, 32'd10, 32'd0, {32'd10, 32'hFFFFFFFF}, 34, 0, 33, 0);
`endif
        run_op("both_start", 1, 1, 32'd5, 32'd6, {32'd0, 32'd30}, 33, 0, 32, 0);
        run_op("stray_div", 1, 0, 32'h12345678, 32'hFFFFFF00,
               m_mul(32'h12345678, 32'hFFFFFF00), 33, 0, 32, 10);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom;
            run_op("mul_rnd", 1, 0, ra, rb, m_mul(ra, rb), 33, 0, 32, 0);
            rb = 32'($urandom_range(1, 1000));
            if (i[0]) rb = -rb;
            run_op("div_rnd", 0, 1, ra, rb, m_div(ra, rb), 34, 0, 33, 0);
        end

        // Abort a divide with an asynchronous reset mid-flight
        @(negedge clock);
        DivStart = 1; A = 32'd1000; B = 32'd7;
        @(negedge clock);
        DivStart = 0;
        repeat (14) @(negedge clock);
        #2 reset = 0;
        #1;
        chk("abort_hilo", {HI, LO}, 64'(0));
        chk("abort_busy", 64'(Busy), 64'(0));
        cur_hi = '0; cur_lo = '0;
        @(negedge clock);
        reset = 1;
        run_op("mul_3x4", 1, 0, 32'd3, 32'd4, {32'd0, 32'd12}, 33, 0, 32, 0);

`ifdef MULT_DIV_DIVZERO_CHECK_EN
        chk("dz_count", 64'(dz_cnt), 64'(1));
`else
        chk("dz_count", 64'(dz_cnt), 64'(0));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div.md
# mult_div

Sequential signed multiply/divide unit for the multicycle MIPS datapath, sitting directly downstream of the control unit. The control unit's Mult/Div states fire a start pulse and wait on `Done`. The block then latches A/B, iterates one bit per cycle, and presents HI/LO results for the control unit to commit via `HI_writeControl`/`LO_writeControl`. It also raises `DivZero`, which the control unit uses to enter its divide-by-zero exception state.

## Interface
- `WIDTH`, 32, operand width; HI/LO are each `WIDTH` bits.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `MultStart`  in  1  one-cycle pulse requesting signed `A*B`.
- `DivStart`  in  1  one-cycle pulse requesting signed `A/B`.
- `A`  in  32  operand from register A; the multiplicand or dividend.
- `B`  in  32  operand from register B; the multiplier or divisor.
- `HI`  out  32  upper product, or remainder.
- `LO`  out  32  lower product, or quotient.
- `Busy`  out  1  high while an operation is in flight.
- `Done`  out  1  one-cycle pulse; HI/LO are valid in this cycle.
- `DivZero`  out  1  one-cycle pulse; division by zero was detected.

## Operation
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE, start handling:
  - `A`/`B` are latched on the edge where a start is sampled high.
  - If `MultStart` and `DivStart` are both high, `MultStart` wins.
- IDLE, next state:
  - MultStart → MULT.
  - DivStart → DIV, unless the zero check below fires.
- MULT: radix-2 Booth algorithm.
  - Working value is a 65-bit {acc[32:0], mplr[31:0]} plus a Booth bit.
  - 32 iterations; each does add/sub/none followed by an arithmetic shift right.
  - Iteration counter is 6 bits and counts 0..31, then → DONE.
- DIV: restoring division on magnitudes |A|, |B|.
  - 32 iterations, counted the same way, then → FIX.
- FIX: sign correction.
  - Quotient is negated if sign(A)≠sign(B); truncation is toward zero.
  - Remainder takes the sign of A.
  - Then → DONE.
- DONE:
  - Load HI/LO.
  - Assert `Done` for one cycle.
  - → IDLE.
- HI/LO hold their value until the next DONE; they never change mid-operation.
- `Busy` = 1 in MULT, DIV and FIX. It is 0 in IDLE and in DONE.
- Start pulses arriving while `Busy` are ignored; they are not queued.
- Overflow case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000 and HI=0. The result wraps and no flag is raised.
- Reset (async, active-low):
  - State → IDLE and counter → 0.
  - HI=0, LO=0, `Busy`=0, `Done`=0, `DivZero`=0.
  - A reset mid-operation aborts the operation; HI/LO read 0.

## Timing
- Start sampled at edge N.
- MULT:
  - Iterations run on edges N+1..N+32.
  - `Done` is high during cycle N+33.
  - Latency is 33 cycles.
- DIV:
  - Iterations run on edges N+1..N+32.
  - FIX is at N+33.
  - `Done` is high during cycle N+34.
  - Latency is 34 cycles.
- A new start may be sampled in the `Done` cycle. It is accepted on the following edge, because IDLE is re-entered then. Back-to-back throughput is therefore 34 cycles for MULT and 35 for DIV.
- All outputs are registered. There is no combinational path from `MultStart`/`DivStart` to any output.

## Configuration
- `MULT_DIV_DIVZERO_CHECK_EN` defined:
  - On DivStart with B==0, IDLE goes straight to DONE.
  - `Done` and `DivZero` are both high in cycle N+1.
  - HI/LO keep their previous values.
- Macro undefined:
  - Divide-by-zero runs the full 34-cycle division; `DivZero` is tied 0.
  - Magnitude result is quotient 0xFFFFFFFF and remainder |A|.
  - FIX sign rules then apply, so A=10, B=0 gives LO=0xFFFFFFFF and HI=10.

## Test plan
- Signed multiply:
  - Stimulus: MultStart, A=7, B=0xFFFFFFFD (−3).
  - Response: `Done` at N+33 with HI=0xFFFFFFFF, LO=0xFFFFFFEB; `Busy` high for exactly 32 cycles.
- Multiply corner:
  - Stimulus: MultStart, A=B=0x80000000.
  - Response: HI=0x40000000, LO=0x00000000.
- Signed divide:
  - Stimulus: DivStart, A=0xFFFFFFF9 (−7), B=2.
  - Response: `Done` at N+34 with LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Repeat with A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero, macro defined:
  - Stimulus: DivStart with B=0.
  - Response: `Done` and `DivZero` both high at N+1; HI/LO unchanged.
  - Macro undefined, A=10, B=0: `Done` at N+34 with LO=0xFFFFFFFF, HI=10, and `DivZero` never asserts.
- Start priority and ignored starts:
  - Stimulus: MultStart and DivStart together.
  - Response: multiply performed, 33-cycle latency.
  - Stimulus: DivStart pulsed at N+10 of a multiply.
  - Response: ignored; exactly one `Done`.
- Reset mid-operation:
  - Stimulus: pull `reset` low at N+15 of a divide, without waiting for a clock edge.
  - Response: immediately HI=LO=0 and `Busy`=0.
  - After release, a fresh MultStart with A=3, B=4 gives LO=12 at N+33.
